// File: rtl/exe_muldiv_ctrl.sv
// Iterative 32x32 multiply / 32/32 divide unit: 32 CALC cycles plus one FIX cycle, done pulses 34 cycles after start.
// Stall holds the pipeline until the done cycle; the divide datapath exists only when MULDIV_DIV_EN is defined.
module exe_muldiv_ctrl (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] porta,
   input  logic [31:0] portb,
   input  logic        flush,
   output logic        stall,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_zero,
   output logic        op_err
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t      state, state_next;
   logic [4:0]  count;
   logic [31:0] acc_hi, acc_lo, mcand;
   logic        neg_lo;
   logic        signed_op, div_zero_req, op_bad, go_calc, go_done;
   logic [31:0] mag_a, mag_b;
   logic [32:0] mul_sum;
   logic [63:0] prod, prod_neg;
   logic [31:0] fix_hi, fix_lo;
`ifdef MULDIV_DIV_EN
   logic        is_div, neg_hi;
   logic [32:0] div_shift;
   logic        div_ge;
   logic [31:0] div_diff;
`endif

   always_comb begin
      signed_op = ~op[0];
      mag_a     = (signed_op && porta[31]) ? -porta : porta;
      mag_b     = (signed_op && portb[31]) ? -portb : portb;
`ifdef MULDIV_DIV_EN
      div_zero_req = op[1] && (portb == 32'd0);
      op_bad       = 1'b0;
`else
      div_zero_req = 1'b0;
      op_bad       = op[1];
`endif
      go_calc = start && !op_bad && !div_zero_req;
      go_done = start && (op_bad || div_zero_req);
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (go_calc)      state_next = CALC;
            else if (go_done) state_next = DONE;
         end
         CALC:    if (count == 5'd31) state_next = FIX;
         FIX:     state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush) state_next = IDLE;
   end

   always_comb begin
      stall = (state == IDLE && start) || state == CALC || state == FIX;
      done  = (state == DONE);
   end

   // One shift-add step: acc_hi:acc_lo is the partial product, multiplier bits shift out of acc_lo.
   always_comb begin
      mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : 33'd0);
      prod     = {acc_hi, acc_lo};
      prod_neg = -prod;
      {fix_hi, fix_lo} = neg_lo ? prod_neg : prod;
`ifdef MULDIV_DIV_EN
      div_shift = {acc_hi, acc_lo[31]};
      div_ge    = div_shift >= {1'b0, mcand};
      div_diff  = div_shift[31:0] - mcand;
      if (is_div) begin
         fix_lo = neg_lo ? -acc_lo : acc_lo;
         fix_hi = neg_hi ? -acc_hi : acc_hi;
      end
`endif
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state    <= IDLE;
         count    <= 5'd0;
         hi       <= 32'd0;
         lo       <= 32'd0;
         div_zero <= 1'b0;
         op_err   <= 1'b0;
         acc_hi   <= 32'd0;
         acc_lo   <= 32'd0;
         mcand    <= 32'd0;
         neg_lo   <= 1'b0;
`ifdef MULDIV_DIV_EN
         is_div   <= 1'b0;
         neg_hi   <= 1'b0;
`endif
      end else begin
         state    <= state_next;
         div_zero <= 1'b0;
         op_err   <= 1'b0;
         count    <= (state == CALC) ? count + 5'd1 : 5'd0;
         case (state)
            IDLE: begin
               if (start) begin
                  // Multiplier and dividend share acc_lo; multiplicand and divisor share mcand.
                  acc_hi <= 32'd0;
                  acc_lo <= mag_a;
                  mcand  <= mag_b;
                  neg_lo <= signed_op && (porta[31] ^ portb[31]);
`ifdef MULDIV_DIV_EN
                  is_div <= op[1];
                  neg_hi <= signed_op && porta[31];
`endif
               end
               if (state_next == DONE) begin
                  div_zero <= div_zero_req;
                  op_err   <= op_bad;
`ifdef MULDIV_DIV_EN
                  if (div_zero_req) begin
                     hi <= porta;
                     lo <= 32'hFFFF_FFFF;
                  end
`endif
               end
            end
            CALC: begin
`ifdef MULDIV_DIV_EN
               if (is_div) begin
                  acc_hi <= div_ge ? div_diff : div_shift[31:0];
                  acc_lo <= {acc_lo[30:0], div_ge};
               end else begin
                  acc_hi <= mul_sum[32:1];
                  acc_lo <= {mul_sum[0], acc_lo[31:1]};
               end
`else
               acc_hi <= mul_sum[32:1];
               acc_lo <= {mul_sum[0], acc_lo[31:1]};
`endif
            end
            FIX: begin
               if (state_next == DONE) begin
                  hi <= fix_hi;
                  lo <= fix_lo;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// Directed bench for exe_muldiv_ctrl: vector table of complete ops plus flush, ignored-start and reset sequences.
module tb_exe_muldiv_ctrl;

   logic        CLK = 1'b0;
   logic        nRST, start, flush;
   logic [1:0]  op;
   logic [31:0] porta, portb;
   logic        stall, done, div_zero, op_err;
   logic [31:0] hi, lo;

   int checks = 0;
   int failures = 0;

   localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a, b, hi, lo;
      logic        dz, err;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   exe_muldiv_ctrl dut (
      .CLK(CLK), .nRST(nRST), .start(start), .op(op), .porta(porta), .portb(portb),
      .flush(flush), .stall(stall), .done(done), .hi(hi), .lo(lo),
      .div_zero(div_zero), .op_err(op_err)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic add_vec(input logic [1:0] o, input logic [31:0] a, b, h, l,
                          input logic dz, err, input int lat);
      vec_t v;
      v.op = o; v.a = a; v.b = b; v.hi = h; v.lo = l; v.dz = dz; v.err = err; v.lat = lat;
      vecs.push_back(v);
   endtask

   // Called at posedge+2; start is seen at the next edge. Operands are scrambled after capture.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, b,
                         output int lat, output int stall_bad);
      op = o; porta = a; portb = b; start = 1'b1;
      #1;
      stall_bad = 0;
      if (stall !== 1'b1 || done !== 1'b0) stall_bad++;
      lat = 0;
      for (int i = 0; i < 100; i++) begin
         next_cycle();
         start = 1'b0; porta = $urandom; portb = $urandom;
         #1;
         lat++;
         if (done === 1'b1) break;
         if (stall !== 1'b1) stall_bad++;
      end
   endtask

   task automatic watch_no_done(input string name, input int n);
      int pulses = 0;
      for (int i = 0; i < n; i++) begin
         next_cycle();
         #1;
         if (done !== 1'b0) pulses++;
      end
      check(name, pulses, 0);
   endtask

   initial begin
      int lat, sb, pulses;
      logic [31:0] prev_hi, prev_lo;

      nRST = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; porta = '0; portb = '0;
      repeat (3) next_cycle();
      #1;
      check("reset_hilo", {hi, lo}, 64'd0);
      check("reset_ctl", {stall, done, div_zero, op_err}, 4'b0000);
      nRST = 1'b1;
      next_cycle();
      #1;
      check("idle_stall", {stall, done}, 2'b00);

      add_vec(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 34);
      add_vec(MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 34);
      add_vec(MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 34);
      add_vec(MULT,  32'd0,         32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 34);
      add_vec(MULTU, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780, 1'b0, 1'b0, 34);
      add_vec(MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b0, 34);
`ifdef MULDIV_DIV_EN
      add_vec(DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 34);
      add_vec(DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1, 1'b0, 1);
      add_vec(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 34);
      add_vec(DIVU,  32'd7,         32'h10,        32'd7,         32'd0,         1'b0, 1'b0, 34);
      add_vec(DIV,   32'd9,         32'd3,         32'd0,         32'd3,         1'b0, 1'b0, 34);
`else
      add_vec(DIV,   32'd9,         32'd3,         32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b1, 1);
      add_vec(DIVU,  32'd100,       32'd0,         32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b1, 1);
`endif

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, sb);
         check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
         check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
         check($sformatf("v%0d_flags", i), {div_zero, op_err}, {vecs[i].dz, vecs[i].err});
         check($sformatf("v%0d_stall_busy", i), sb, 0);
         check($sformatf("v%0d_stall_done", i), stall, 1'b0);
         next_cycle();
         #1;
         check($sformatf("v%0d_after", i), {done, div_zero, op_err, stall}, 4'b0000);
         prev_hi = vecs[i].hi;
         prev_lo = vecs[i].lo;
      end

      // Flush in cycle N+10 of MULTU 5x5.
      op = MULTU; porta = 32'd5; portb = 32'd5; start = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         next_cycle();
         start = 1'b0;
         if (k == 10) flush = 1'b1;
      end
      #1;
      check("flush_stall_n10", stall, 1'b1);
      next_cycle();
      flush = 1'b0;
      #1;
      check("flush_n11", {stall, done}, 2'b00);
      watch_no_done("flush_no_done", 40);
      check("flush_hilo", {hi, lo}, {prev_hi, prev_lo});

      // Flush beats a simultaneous start.
      op = MULTU; porta = 32'd2; portb = 32'd2; start = 1'b1; flush = 1'b1;
      next_cycle();
      start = 1'b0; flush = 1'b0;
      #1;
      check("flush_start_stall", stall, 1'b0);
      watch_no_done("flush_start_no_done", 40);

      run_op(MULTU, 32'd5, 32'd5, lat, sb);
      check("post_flush_latency", lat, 34);
      check("post_flush_result", {hi, lo}, 64'd25);
      check("post_flush_stall", sb, 0);
      next_cycle();

      // New start at N+5 of MULTU 3x4 is ignored.
      op = MULTU; porta = 32'd3; portb = 32'd4; start = 1'b1;
      lat = 0;
      for (int k = 1; k <= 100; k++) begin
         next_cycle();
         start = (k == 5);
         if (k == 5) begin op = MULT; porta = 32'd100; portb = 32'hFFFF_FF38; end
         #1;
         lat = k;
         if (done === 1'b1) break;
      end
      check("ignore_latency", lat, 34);
      check("ignore_result", {hi, lo}, 64'd12);
      start = 1'b0;
      watch_no_done("ignore_no_second", 40);

      // Reset at N+20 of MULTU 6x7.
      op = MULTU; porta = 32'd6; portb = 32'd7; start = 1'b1;
      pulses = 0;
      for (int k = 1; k <= 20; k++) begin
         next_cycle();
         start = 1'b0;
         if (k == 20) nRST = 1'b0;
         #1;
         if (done !== 1'b0) pulses++;
      end
      next_cycle();
      nRST = 1'b1;
      #1;
      check("rst_mid_hilo", {hi, lo}, 64'd0);
      check("rst_mid_ctl", {stall, done, div_zero, op_err}, 4'b0000);
      check("rst_mid_early_done", pulses, 0);
      watch_no_done("rst_mid_no_done", 40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/exe_muldiv_ctrl.md
EXE_MULDIV_CTRL -- requirements
Module: exe_muldiv_ctrl

Interface
REQ-001 The module SHALL have port CLK, input, 1, sole clock; all state updates on its rising edge.
REQ-002 The module SHALL have port nRST, input, 1, reset that is synchronous and active-low.
REQ-003 The module SHALL have port start, input, 1, EX-stage request to begin a multiply/divide op.
REQ-004 The module SHALL have port op, input, 2, 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 The module SHALL have port porta, input, 32, rs operand after forwarding muxes.
REQ-006 The module SHALL have port portb, input, 32, rt operand after forwarding muxes.
REQ-007 The module SHALL have port flush, input, 1, pipeline flush; aborts the op in flight.
REQ-008 The module SHALL have port stall, output, 1, freezes IF/ID/EX latches while the op is in progress.
REQ-009 The module SHALL have port done, output, 1, one-cycle pulse; hi/lo updated this cycle.
REQ-010 The module SHALL have port hi, output, 32, MULT: upper product; DIV: remainder.
REQ-011 The module SHALL have port lo, output, 32, MULT: lower product; DIV: quotient.
REQ-012 The module SHALL have port div_zero, output, 1, qualifies done: divisor was zero.
REQ-013 The module SHALL have port op_err, output, 1, qualifies done: op not supported in this build.

Function
REQ-014 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-015 The FSM SHALL make these transitions:
- IDLE->CALC on start with a legal nonzero-divisor op;
- CALC->FIX after exactly 32 iterations, counted by a 5-bit counter that wraps 31->0;
- FIX->DONE unconditionally;
- DONE->IDLE unconditionally.
REQ-016 The module SHALL capture operands only in the IDLE cycle where start=1; later changes on porta/portb SHALL have no effect.
REQ-017 Latency: with start sampled at edge N, done SHALL be 1 during cycle N+34 and 0 in all other cycles.
REQ-018 stall SHALL be combinational: 1 when (IDLE and start) or state is CALC or FIX; 0 in DONE, so the consumer advances on the done cycle.
REQ-019 start asserted outside IDLE SHALL be ignored.
REQ-020 Multiply SHALL be shift-add on operand magnitudes, with two's-complement negation of the 64-bit result in FIX when MULT operand signs differ.
REQ-021 Divide SHALL be restoring division on magnitudes:
- the quotient truncates toward zero;
- the remainder takes the sign of the dividend;
- signs are fixed in FIX.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0x00000000, div_zero=0.
REQ-023 A divide with portb=0 SHALL skip CALC and FIX (IDLE->DONE) and complete with:
- done at N+1;
- hi=porta, lo=0xFFFFFFFF;
- div_zero=1.
REQ-024 hi/lo SHALL update only on the IDLE/FIX->DONE transition and hold between completions.
REQ-025 flush=1 in any state SHALL force IDLE at the next edge, with no done and hi/lo unchanged; flush overrides a simultaneous start.
REQ-026 div_zero and op_err SHALL be 0 whenever done=0.

Reset
REQ-027 On a rising edge with nRST=0, the module SHALL set state=IDLE, counter=0, hi=0, lo=0, done=0, div_zero=0, op_err=0, which also makes stall=0 unless start=1.
REQ-028 Reset during CALC or FIX SHALL abandon the op with no done pulse.
REQ-029 nRST SHALL take priority over flush and start.

Configuration
REQ-030 With MULDIV_DIV_EN defined, the module SHALL implement divide per REQ-021..023.
REQ-031 With MULDIV_DIV_EN undefined, the module SHALL omit the divide datapath, and op 10/11 SHALL go IDLE->DONE with:
- done at N+1;
- op_err=1;
- hi/lo unchanged.

Verification
REQ-032 The bench SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at N+34, hi=0xFFFFFFFE, lo=0x00000001, stall high cycles N..N+33.
REQ-033 The bench SHALL cover: MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-034 The bench SHALL cover: DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100 / 0 -> done at N+1, div_zero=1, hi=100, lo=0xFFFFFFFF.
REQ-035 The bench SHALL cover: flush at N+10 of MULTU 5x5 -> IDLE at N+11, no done, hi/lo keep prior values, stall=0 from N+11.
REQ-036 The bench SHALL cover: start with new operands at N+5 of an in-flight op -> ignored, result reflects original operands; nRST=0 at N+20 -> all outputs 0, no done.
REQ-037 The bench SHALL cover: build without MULDIV_DIV_EN, DIV 9/3 -> done at N+1, op_err=1, hi/lo unchanged.
